// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: bundle of requester-side and transmitter-side signals
// around the UART transmit arbiter.
//   master : arbiter view (drives req_ready, uart_data, uart_send, grant_id, busy)
//   slave  : environment view (drives req_valid, req_data, req_last, uart_ready)
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           uart_data;
  logic                 uart_send;
  logic                 uart_ready;
  logic [GW-1:0]        grant_id;
  logic                 busy;

  modport master (
    input  req_valid, req_data, req_last, uart_ready,
    output req_ready, uart_data, uart_send, grant_id, busy
  );

  modport slave (
    output req_valid, req_data, req_last, uart_ready,
    input  req_ready, uart_data, uart_send, grant_id, busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one byte-wide UART transmitter between
// NUM_REQ byte-stream requesters, with packet lock until a byte flagged last or
// until the owner stalls for LOCK_TIMEOUT cycles (0 = never time out).
// Ports: clk, rst (async, active-high), bus (uart_tx_arbiter_if.master):
//   req_valid/req_data/req_last in, req_ready out (1-cycle accept pulse),
//   uart_data/uart_send out, uart_ready in, grant_id/busy out. All outputs registered.
// Option: define ARB_PREFIX_EN to precede every packet granted from IDLE with a
//   tag byte 0x30+grant_id (no req_ready pulse for the tag).
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int LOCK_TIMEOUT = 100000
) (
  input logic               clk,
  input logic               rst,
  uart_tx_arbiter_if.master bus
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

`ifdef ARB_PREFIX_EN
  typedef enum logic [2:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE, HOLD, PREFIX} state_t;
`else
  typedef enum logic [2:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE, HOLD} state_t;
`endif

  state_t             state;
  logic [GW-1:0]      ptr;
  logic [GW-1:0]      grant_q;
  logic               lock_q;
  logic [CW-1:0]      cnt;
  logic [NUM_REQ-1:0] ready_q;
  logic [7:0]         data_q;
  logic               send_q;
  logic               busy_q;
`ifdef ARB_PREFIX_EN
  logic               tag_pend;  // tag byte is on the wire, data byte still owed
`endif

  // First valid requester at or after ptr, wrapping. Scanning from the far end
  // lets the closest match overwrite, so no early exit is needed.
  logic [GW-1:0] pick;
  logic          any_valid;
  always_comb begin
    pick = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      logic [GW-1:0] idx;
      idx = GW'((int'(ptr) + k) % NUM_REQ);
      if (bus.req_valid[idx]) pick = idx;
    end
  end
  assign any_valid = |bus.req_valid;

`ifndef ARB_PREFIX_EN
  logic [7:0] pick_data;
  logic       pick_last;
  assign pick_data = bus.req_data[8*pick +: 8];
  assign pick_last = bus.req_last[pick];
`endif

  // Byte of the current owner, used when continuing a locked packet.
  logic [7:0]    gnt_data;
  logic          gnt_last;
  logic [GW-1:0] next_ptr;
  assign gnt_data = bus.req_data[8*grant_q +: 8];
  assign gnt_last = bus.req_last[grant_q];
  assign next_ptr = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      grant_q  <= '0;
      lock_q   <= 1'b0;
      cnt      <= '0;
      ready_q  <= '0;
      data_q   <= '0;
      send_q   <= 1'b0;
      busy_q   <= 1'b0;
`ifdef ARB_PREFIX_EN
      tag_pend <= 1'b0;
`endif
    end else begin
      // send and accept are single-cycle strobes
      ready_q <= '0;
      send_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.uart_ready && any_valid) begin
            grant_q <= pick;
            busy_q  <= 1'b1;
            send_q  <= 1'b1;
`ifdef ARB_PREFIX_EN
            data_q   <= 8'h30 + 8'(pick);
            tag_pend <= 1'b1;
            state    <= PREFIX;
`else
            data_q        <= pick_data;
            ready_q[pick] <= 1'b1;
            lock_q        <= ~pick_last;
            state         <= SEND;
`endif
          end
        end
        SEND: state <= WAIT_BUSY;
`ifdef ARB_PREFIX_EN
        PREFIX: state <= WAIT_BUSY;
`endif
        WAIT_BUSY: begin
          if (!bus.uart_ready) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (bus.uart_ready) begin
`ifdef ARB_PREFIX_EN
            // Tag done: the owner's first byte goes out without re-arbitrating;
            // it has been holding that byte since it was granted.
            if (tag_pend) begin
              tag_pend         <= 1'b0;
              data_q           <= gnt_data;
              send_q           <= 1'b1;
              ready_q[grant_q] <= 1'b1;
              lock_q           <= ~gnt_last;
              state            <= SEND;
            end else
`endif
            if (lock_q) begin
              cnt   <= '0;
              state <= HOLD;
            end else begin
              busy_q <= 1'b0;
              ptr    <= next_ptr;
              state  <= IDLE;
            end
          end
        end
        HOLD: begin
          if (bus.req_valid[grant_q]) begin
            // A valid owner is not stalling, so the timeout does not advance.
            if (bus.uart_ready) begin
              data_q           <= gnt_data;
              send_q           <= 1'b1;
              ready_q[grant_q] <= 1'b1;
              lock_q           <= ~gnt_last;
              state            <= SEND;
            end
          end else if (LOCK_TIMEOUT != 0 && cnt == CW'(LOCK_TIMEOUT - 1)) begin
            lock_q <= 1'b0;
            busy_q <= 1'b0;
            ptr    <= next_ptr;
            state  <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.uart_data = data_q;
  assign bus.uart_send = send_q;
  assign bus.grant_id  = grant_q;
  assign bus.busy      = busy_q;

endmodule
